kf8088_interrupt_acknowledge: RTL and testbench
===============================================

// Module: kf8088_interrupt_acknowledge
//
// PURPOSE
//  CPU-side initiator of the 8259 interrupt handshake. Samples INTR at instruction
//  boundaries, runs the two-pulse locked INTA bus sequence and captures the vector
//  byte driven by the 8259 on the second pulse. Also latches NMI edges, which skip
//  INTA and return a fixed vector. Sits between the 8259 and the core's sequencer.
//
// PARAMETERS
//  INTA_ACTIVE_CYCLES  2      clocks INTA_n low per pulse before ready is checked (>=1)
//  INTA_IDLE_CYCLES    2      clocks INTA_n high between the two pulses (>=1)
//  NMI_VECTOR          8'h02  vector returned for NMI
//
// PORTS
//  clock                    in   1  system clock, all logic on posedge
//  reset_n                  in   1  asynchronous, active-low reset
//  interrupt                in   1  INTR level from 8259
//  nmi                      in   1  NMI, rising-edge sensitive
//  interrupt_enable         in   1  CPU IF flag; gates interrupt only, never nmi
//  accept_window            in   1  1-clock strobe: core is at an instruction boundary
//  ready                    in   1  bus ready; low stretches the last active INTA clock
//  data_bus_in              in   8  bus read data (vector from 8259)
//  interrupt_acknowledge_n  out  1  INTA_n strobe to 8259
//  lock_n                   out  1  bus lock, low across the whole INTA sequence
//  vector                   out  8  captured vector; holds until next capture
//  vector_valid             out  1  1-clock pulse, vector is new
//  busy                     out  1  high whenever state != IDLE
//
// BEHAVIOUR
//  Reset: interrupt_acknowledge_n=1, lock_n=1, vector=0, vector_valid=0, busy=0,
//   nmi_pending=0, nmi sample register=1 (nmi high at release is not an edge).
//  All outputs registered. States: IDLE, INTA1, GAP, INTA2, DONE.
//  IDLE + accept_window: nmi_pending -> vector<=NMI_VECTOR, clear pending, ->DONE
//   (NMI wins over INTR); else interrupt & interrupt_enable -> INTA1; else stay.
//  accept_window outside IDLE is ignored.
//  INTA1: INTA_n=0, lock_n=0; count INTA_ACTIVE_CYCLES; on last count hold while
//   ready=0; leave when ready=1 -> GAP.
//  GAP: INTA_n=1, lock_n=0; INTA_IDLE_CYCLES clocks, ready ignored -> INTA2.
//  INTA2: as INTA1; on the clock leaving (last count, ready=1) vector<=data_bus_in.
//  DONE: INTA_n=1, lock_n=1, vector_valid=1 for exactly one clock -> IDLE.
//  Latency (defaults, ready=1): accept at clk0; INTA1 clk1-2, GAP 3-4, INTA2 5-6,
//   valid clk7. NMI path: accept clk0, valid clk1.
//  interrupt dropping mid-sequence: sequence completes; whatever byte is on the bus
//   is captured (8259 supplies the spurious IR7 vector).
//  NMI edge: nmi & ~nmi_q sets nmi_pending; kept until serviced. New edge on the
//   same clock pending is cleared -> set wins, stays pending.
//  NMI edge during INTA sequence: latched; served at next accept_window after IDLE.
//  Counter width $clog2(max(INTA_ACTIVE_CYCLES,INTA_IDLE_CYCLES)+1); reloaded on
//   every state entry, never wraps.
//  reset_n low mid-sequence: immediate return to reset values, INTA_n/lock_n high.
//
// STRUCTURE
//  Package kf8088_pkg: state enum typedef, NMI_VECTOR default constant.
//  Sub-module kf8088_nmi_edge_latch: nmi sampler + pending flag with set/clear ports.
//  FSM, counter and vector register stay in this module.
//
// TESTING
//  1 interrupt=1, IF=1, accept clk0, ready=1, data=8'h0B at INTA2 -> INTA_n low clk1-2
//    and 5-6, lock_n low clk1-6, vector=8'h0B, vector_valid only at clk7.
//  2 Same, ready=0 for 3 clocks at end of INTA2 -> INTA2 lasts 5 clocks, valid at clk10.
//  3 interrupt=1, IF=0, accept strobes -> no INTA_n/lock_n activity, busy stays 0.
//  4 nmi rising edge and interrupt=1, IF=1, accept -> vector=8'h02, valid next clock,
//    no INTA_n pulse; next accept then runs the INTA sequence.
//  5 nmi edge during GAP -> INTA sequence unaffected; next accept in IDLE gives 8'h02.
//  6 reset_n low during INTA1 -> INTA_n=1, lock_n=1, busy=0 asynchronously; nmi held
//    high through release produces no NMI.

Source files
------------

// File: rtl/kf8088_pkg.sv
// Shared types and constants for the kf8088 interrupt acknowledge block.
//  kf8088_state_e      : FSM state encoding (also exported for debug)
//  NMI_VECTOR_DEFAULT  : vector returned when an NMI is serviced
//  max2                : elaboration-time helper for counter sizing
package kf8088_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INTA1 = 3'd1,
    ST_GAP   = 3'd2,
    ST_INTA2 = 3'd3,
    ST_DONE  = 3'd4
  } kf8088_state_e;

  localparam logic [7:0] NMI_VECTOR_DEFAULT = 8'h02;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/kf8088_interrupt_acknowledge_if.sv
// Bus/handshake bundle between the kf8088 interrupt acknowledge unit, the 8259
// and the core sequencer.
//  master : the acknowledge unit (samples requests, drives INTA_n/lock_n/vector)
//  slave  : the environment (8259 + sequencer)
// Handshake: accept_window is a 1-clock strobe from the core; vector_valid is a
// 1-clock pulse back with vector stable from that clock until the next capture.
// ready low stretches the last active INTA clock; it is ignored elsewhere.
interface kf8088_interrupt_acknowledge_if;
  import kf8088_pkg::*;

  logic          interrupt;
  logic          nmi;
  logic          interrupt_enable;
  logic          accept_window;
  logic          ready;
  logic [7:0]    data_bus_in;
  logic          interrupt_acknowledge_n;
  logic          lock_n;
  logic [7:0]    vector;
  logic          vector_valid;
  logic          busy;
  kf8088_state_e state;

  modport master (
    input  interrupt, nmi, interrupt_enable, accept_window, ready, data_bus_in,
    output interrupt_acknowledge_n, lock_n, vector, vector_valid, busy, state
  );

  modport slave (
    output interrupt, nmi, interrupt_enable, accept_window, ready, data_bus_in,
    input  interrupt_acknowledge_n, lock_n, vector, vector_valid, busy, state
  );

endinterface

// File: rtl/kf8088_nmi_edge_latch.sv
// NMI rising-edge detector with a sticky pending flag.
//  clock, reset_n : system clock, async active-low reset
//  nmi            : raw NMI level
//  clear          : request to clear pending (NMI being serviced)
//  pending        : an NMI edge is waiting for service
module kf8088_nmi_edge_latch (
  input  logic clock,
  input  logic reset_n,
  input  logic nmi,
  input  logic clear,
  output logic pending
);

  logic nmi_q;
  logic nmi_rise;

  assign nmi_rise = nmi & ~nmi_q;

  // nmi_q resets high so an NMI already asserted at reset release is not an edge.
  // A fresh edge on the clock the flag is cleared keeps it pending.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      nmi_q   <= 1'b1;
      pending <= 1'b0;
    end else begin
      nmi_q <= nmi;
      if (nmi_rise)   pending <= 1'b1;
      else if (clear) pending <= 1'b0;
    end
  end

endmodule

// File: rtl/kf8088_interrupt_acknowledge.sv
// CPU-side initiator of the 8259 interrupt handshake.
// At an accept_window strobe in IDLE it either services a pending NMI (fixed
// vector, no bus cycle) or, if INTR is high and enabled, runs two locked INTA
// pulses and captures the vector byte on the second one.
//  clock, reset_n : system clock, async active-low reset
//  bus            : handshake bundle (master modport), includes debug state
module kf8088_interrupt_acknowledge
  import kf8088_pkg::*;
#(
  parameter int         INTA_ACTIVE_CYCLES = 2,
  parameter int         INTA_IDLE_CYCLES   = 2,
  parameter logic [7:0] NMI_VECTOR         = NMI_VECTOR_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  kf8088_interrupt_acknowledge_if.master bus
);

  localparam int CNT_W = $clog2(max2(INTA_ACTIVE_CYCLES, INTA_IDLE_CYCLES) + 1);
  // Counter holds clocks remaining after the current one; zero marks the last.
  localparam logic [CNT_W-1:0] ACTIVE_LOAD = CNT_W'(INTA_ACTIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD   = CNT_W'(INTA_IDLE_CYCLES - 1);

  kf8088_state_e    state;
  logic [CNT_W-1:0] cnt;
  logic             inta_n_r;
  logic             lock_n_r;
  logic [7:0]       vector_r;
  logic             valid_r;
  logic             busy_r;
  logic             nmi_pending;
  logic             nmi_clear;
  logic             last_count;

  assign last_count = (cnt == '0);
  assign nmi_clear  = (state == ST_IDLE) && bus.accept_window && nmi_pending;

  kf8088_nmi_edge_latch u_nmi (
    .clock   (clock),
    .reset_n (reset_n),
    .nmi     (bus.nmi),
    .clear   (nmi_clear),
    .pending (nmi_pending)
  );

  // Outputs are registered: each transition loads the values for the state
  // being entered, so pins change on the same edge as the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      inta_n_r <= 1'b1;
      lock_n_r <= 1'b1;
      vector_r <= 8'h00;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.accept_window) begin
            if (nmi_pending) begin
              vector_r <= NMI_VECTOR;
              valid_r  <= 1'b1;
              busy_r   <= 1'b1;
              state    <= ST_DONE;
            end else if (bus.interrupt && bus.interrupt_enable) begin
              cnt      <= ACTIVE_LOAD;
              inta_n_r <= 1'b0;
              lock_n_r <= 1'b0;
              busy_r   <= 1'b1;
              state    <= ST_INTA1;
            end
          end
        end
        ST_INTA1: begin
          if (!last_count) begin
            cnt <= cnt - CNT_W'(1);
          end else if (bus.ready) begin
            cnt      <= IDLE_LOAD;
            inta_n_r <= 1'b1;
            state    <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (!last_count) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            cnt      <= ACTIVE_LOAD;
            inta_n_r <= 1'b0;
            state    <= ST_INTA2;
          end
        end
        ST_INTA2: begin
          if (!last_count) begin
            cnt <= cnt - CNT_W'(1);
          end else if (bus.ready) begin
            // Whatever is on the bus is taken, including the 8259's spurious IR7.
            vector_r <= bus.data_bus_in;
            inta_n_r <= 1'b1;
            lock_n_r <= 1'b1;
            valid_r  <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          inta_n_r <= 1'b1;
          lock_n_r <= 1'b1;
          busy_r   <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.interrupt_acknowledge_n = inta_n_r;
  assign bus.lock_n                  = lock_n_r;
  assign bus.vector                  = vector_r;
  assign bus.vector_valid            = valid_r;
  assign bus.busy                    = busy_r;
  assign bus.state                   = state;

endmodule

// File: tb/tb_kf8088_interrupt_acknowledge.sv
// Bench for kf8088_interrupt_acknowledge: per-scenario tasks with inline
// pin checks, plus a vector scoreboard fed when a request is issued and
// drained whenever vector_valid pulses.
module tb_kf8088_interrupt_acknowledge;
  import kf8088_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  kf8088_interrupt_acknowledge_if bus_if ();

  kf8088_interrupt_acknowledge dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clock) begin
    if (reset_n && bus_if.vector_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_valid: vector=%h, nothing expected", bus_if.vector);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus_if.vector !== mon_exp) begin
          errors++;
          $display("FAIL sb_vector: got %h expected %h", bus_if.vector, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / scenario tasks ----------------
  // Full default-timing INTA sequence; optionally raises nmi at cycle nmi_at.
  task automatic run_inta_seq(input logic [7:0] d, input int nmi_at, input string tag);
    logic [3:0] exp_s, act_s;
    bus_if.interrupt        = 1'b1;
    bus_if.interrupt_enable = 1'b1;
    bus_if.ready            = 1'b1;
    bus_if.data_bus_in      = 8'hFF;
    bus_if.accept_window    = 1'b1;
    exp_q.push_back(d);
    tick;
    bus_if.accept_window = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      bus_if.data_bus_in = (c == 5 || c == 6) ? d : 8'hFF;
      if (c == nmi_at) bus_if.nmi = 1'b1;
      exp_s = {!(c == 1 || c == 2 || c == 5 || c == 6), !(c >= 1 && c <= 6),
               (c == 7), (c <= 7)};
      act_s = {bus_if.interrupt_acknowledge_n, bus_if.lock_n,
               bus_if.vector_valid, bus_if.busy};
      checks++;
      if (act_s !== exp_s) begin
        errors++;
        $display("FAIL %s_c%0d {inta_n,lock_n,valid,busy}: got %b expected %b",
                 tag, c, act_s, exp_s);
      end
      tick;
    end
    checks++;
    if (bus_if.vector !== d) begin
      errors++;
      $display("FAIL %s_hold: vector got %h expected %h", tag, bus_if.vector, d);
    end
  endtask

  task automatic test_reset;
    logic [3:0] act_s;
    bus_if.interrupt        = 1'b0;
    bus_if.nmi              = 1'b0;
    bus_if.interrupt_enable = 1'b0;
    bus_if.accept_window    = 1'b0;
    bus_if.ready            = 1'b1;
    bus_if.data_bus_in      = 8'h00;
    #12;
    act_s = {bus_if.interrupt_acknowledge_n, bus_if.lock_n, bus_if.vector_valid, bus_if.busy};
    checks++;
    if (act_s !== 4'b1100 || bus_if.vector !== 8'h00 || bus_if.state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_values: pins %b vector %h state %0d expected 1100 00 0",
               act_s, bus_if.vector, bus_if.state);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick;
    act_s = {bus_if.interrupt_acknowledge_n, bus_if.lock_n, bus_if.vector_valid, bus_if.busy};
    checks++;
    if (act_s !== 4'b1100) begin
      errors++;
      $display("FAIL reset_release: pins got %b expected 1100", act_s);
    end
  endtask

  task automatic test_basic_inta;
    run_inta_seq(8'h0B, 0, "t1");
  endtask

  task automatic test_ready_stretch;
    logic [3:0] exp_s, act_s;
    bus_if.interrupt        = 1'b1;
    bus_if.interrupt_enable = 1'b1;
    bus_if.ready            = 1'b1;
    bus_if.accept_window    = 1'b1;
    exp_q.push_back(8'h5A);
    tick;
    bus_if.accept_window = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      bus_if.ready       = (c >= 6 && c <= 8) ? 1'b0 : 1'b1;
      bus_if.data_bus_in = (c >= 5 && c <= 9) ? 8'h5A : 8'hFF;
      if (c == 3) bus_if.interrupt = 1'b0;  // dropping INTR must not abort
      exp_s = {!(c == 1 || c == 2 || (c >= 5 && c <= 9)), !(c >= 1 && c <= 9),
               (c == 10), (c <= 10)};
      act_s = {bus_if.interrupt_acknowledge_n, bus_if.lock_n,
               bus_if.vector_valid, bus_if.busy};
      checks++;
      if (act_s !== exp_s) begin
        errors++;
        $display("FAIL t2_c%0d {inta_n,lock_n,valid,busy}: got %b expected %b",
                 c, act_s, exp_s);
      end
      tick;
    end
    bus_if.ready = 1'b1;
  endtask

  task automatic test_if_masked;
    logic [3:0] act_s;
    bus_if.interrupt        = 1'b1;
    bus_if.interrupt_enable = 1'b0;
    for (int c = 0; c < 12; c++) begin
      bus_if.accept_window = (c % 3 == 0);
      tick;
      act_s = {bus_if.interrupt_acknowledge_n, bus_if.lock_n, bus_if.vector_valid, bus_if.busy};
      checks++;
      if (act_s !== 4'b1100) begin
        errors++;
        $display("FAIL t3_c%0d masked: pins got %b expected 1100", c, act_s);
      end
    end
    bus_if.accept_window = 1'b0;
  endtask

  task automatic test_nmi_priority;
    logic [3:0] act_s;
    bus_if.nmi = 1'b1;
    tick;
    tick;
    bus_if.interrupt        = 1'b1;
    bus_if.interrupt_enable = 1'b1;
    bus_if.accept_window    = 1'b1;
    exp_q.push_back(8'h02);
    tick;
    bus_if.accept_window = 1'b0;
    act_s = {bus_if.interrupt_acknowledge_n, bus_if.lock_n, bus_if.vector_valid, bus_if.busy};
    checks++;
    if (act_s !== 4'b1111) begin
      errors++;
      $display("FAIL t4_nmi_c1: pins got %b expected 1111", act_s);
    end
    tick;
    act_s = {bus_if.interrupt_acknowledge_n, bus_if.lock_n, bus_if.vector_valid, bus_if.busy};
    checks++;
    if (act_s !== 4'b1100 || bus_if.vector !== 8'h02) begin
      errors++;
      $display("FAIL t4_nmi_c2: pins %b vector %h expected 1100 02", act_s, bus_if.vector);
    end
    bus_if.nmi = 1'b0;
    run_inta_seq(8'hC4, 0, "t4_intr");
  endtask

  task automatic test_nmi_during_gap;
    logic [3:0] act_s;
    run_inta_seq(8'h21, 3, "t5");
    bus_if.interrupt     = 1'b0;
    bus_if.accept_window = 1'b1;
    exp_q.push_back(8'h02);
    tick;
    bus_if.accept_window = 1'b0;
    act_s = {bus_if.interrupt_acknowledge_n, bus_if.lock_n, bus_if.vector_valid, bus_if.busy};
    checks++;
    if (act_s !== 4'b1111) begin
      errors++;
      $display("FAIL t5_nmi_served: pins got %b expected 1111", act_s);
    end
    tick;
    bus_if.nmi = 1'b0;
  endtask

  task automatic test_reset_mid_sequence;
    logic [3:0] act_s;
    bus_if.interrupt        = 1'b1;
    bus_if.interrupt_enable = 1'b1;
    bus_if.accept_window    = 1'b1;
    tick;
    bus_if.accept_window = 1'b0;
    checks++;
    if (bus_if.interrupt_acknowledge_n !== 1'b0) begin
      errors++;
      $display("FAIL t6_in_inta1: inta_n got %b expected 0", bus_if.interrupt_acknowledge_n);
    end
    bus_if.nmi = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    act_s = {bus_if.interrupt_acknowledge_n, bus_if.lock_n, bus_if.vector_valid, bus_if.busy};
    checks++;
    if (act_s !== 4'b1100 || bus_if.vector !== 8'h00) begin
      errors++;
      $display("FAIL t6_async_reset: pins %b vector %h expected 1100 00", act_s, bus_if.vector);
    end
    tick;
    tick;
    @(negedge clock);
    reset_n = 1'b1;
    tick;
    bus_if.interrupt     = 1'b0;
    bus_if.accept_window = 1'b1;
    tick;
    bus_if.accept_window = 1'b0;
    for (int c = 0; c < 3; c++) begin
      act_s = {bus_if.interrupt_acknowledge_n, bus_if.lock_n, bus_if.vector_valid, bus_if.busy};
      checks++;
      if (act_s !== 4'b1100) begin
        errors++;
        $display("FAIL t6_no_nmi_c%0d: pins got %b expected 1100", c, act_s);
      end
      tick;
    end
    bus_if.nmi = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset;
    test_basic_inta;
    test_ready_stretch;
    test_if_masked;
    test_nmi_priority;
    test_nmi_during_gap;
    test_reset_mid_sequence;
    tick;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d vectors never produced, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
